// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the rx/tx state machines.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  // Width of a counter that must hold 0 .. n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst (sync active-high, loads INIT), d (async in), q (synchronized out).
module uart_sync2 #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: recovers bytes from RX, one-cycle valid / frame_err strobes.
// Latency: ~2 + H + 9*CLKS_PER_BIT + 1 clk from start-bit falling edge to strobe.
// Backpressure: none; consumer must take data_out on the valid cycle (it holds anyway).
// Ports: clk, RST (sync active-high), RX (async line, idles high),
//        data_out[7:0], valid, frame_err, busy.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF_C = CW'(H);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_rx_fsm: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

  uart_sync2 #(.INIT(1'b1)) u_sync (
    .clk (clk),
    .rst (RST),
    .d   (RX),
    .q   (rx_s)
  );

  // busy is written alongside every state change so it always equals state!=IDLE.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          // Recheck the line at mid start bit to reject short glitches.
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          // Counter phase is now mid-bit, so a full bit period lands on the next centre.
          if (cnt == LAST_C) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
          if (cnt == LAST_C) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shreg;
              valid    <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK_WAIT: begin
          // A held-low line must return high before another frame is accepted.
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

  localparam int CPB = 10;
  localparam int H   = (CPB - 1) / 2;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t exp_q[$];
  int   vtimes[$];

  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .RST       (rst),
    .RX        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (valid || frame_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe valid=%0b frame_err=%0b data_out=%h (nothing expected)",
                 valid, frame_err, data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (valid !== !e.err || frame_err !== e.err || data_out !== e.data) begin
          errors++;
          $display("FAIL strobe got valid=%0b frame_err=%0b data_out=%h, want valid=%0b frame_err=%0b data_out=%h",
                   valid, frame_err, data_out, !e.err, e.err, e.data);
        end
      end
      if (valid) vtimes.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    rx = 1'b1;
  endtask

  task automatic expect_ok(input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.err  = 1'b1;
    e.data = held;
    exp_q.push_back(e);
  endtask

  initial begin
    int busy_cnt;
    int wait_cyc;
    logic [7:0] b55;

    rst = 1'b1;
    rx  = 1'b1;
    cycles(3);
    rst = 1'b0;
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Good frame 0x4A
    cycles(40);
    expect_ok(8'h4A);
    send_byte(8'h4A, 1'b1);
    cycles(20);
    chk("good_busy_after", 32'(busy), 32'h0);
    chk("good_data_out", 32'(data_out), 32'h4A);
    chk("good_queue_drained", 32'(exp_q.size()), 32'h0);

    // Glitch: 3 low cycles must be rejected at mid start bit
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      if (busy) busy_cnt++;
    end
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_seen", 32'(busy_cnt > 0), 32'h1);
    chk("glitch_busy_bounded", 32'(busy_cnt <= H + 3), 32'h1);
    chk("glitch_busy_after", 32'(busy), 32'h0);

    // Framing error on 0xA5; data_out must keep 0x4A
    expect_err(8'h4A);
    send_byte(8'hA5, 1'b0);
    cycles(20);
    chk("ferr_data_held", 32'(data_out), 32'h4A);
    chk("ferr_busy_after", 32'(busy), 32'h0);
    expect_ok(8'h3C);
    send_byte(8'h3C, 1'b1);
    cycles(20);
    chk("after_ferr_data", 32'(data_out), 32'h3C);

    // Back-to-back 0x00 then 0xFF, no idle gap
    vtimes.delete();
    expect_ok(8'h00);
    expect_ok(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    cycles(20);
    chk("b2b_pulse_count", 32'(vtimes.size()), 32'd2);
    if (vtimes.size() == 2)
      chk("b2b_spacing", 32'(vtimes[1] - vtimes[0]), 32'd100);
    chk("b2b_data_out", 32'(data_out), 32'hFF);

    // Reset during data bit 4 of 0x55
    b55 = 8'h55;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(b55[i]);
    rx = b55[4];
    cycles(5);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("midrst_data_out", 32'(data_out), 32'h00);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    cycles(30);
    expect_ok(8'h81);
    send_byte(8'h81, 1'b1);
    cycles(20);
    chk("after_rst_data", 32'(data_out), 32'h81);

    // Bounded drain of any outstanding expectations
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 500) begin
      cycles(1);
      wait_cyc++;
    end
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
